// File: rtl/timer_deadtime.sv
// Complementary PWM dead-time generator: splits the timer PWM into a high/low gate-drive
// pair with programmable dead time on each transition and a sticky fault shutdown.
module timer_deadtime #(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    input  logic                pol_h_i,
    input  logic                pol_l_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic                pwm_h_o,
    output logic                pwm_l_o,
    output logic                fault_o,
    output logic                busy_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOW   = 3'd1;
    localparam logic [2:0] DT_H  = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] DT_L  = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] cnt_next;
    logic                pwm_q;
    logic                h_act;
    logic                l_act;
    logic                fault_q;
    logic                busy_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;

        if (fault_i) begin
            state_next = FAULT;
        end else if (state == FAULT) begin
            if (fault_clr_i) begin
                state_next = IDLE;
            end
        end else if (!en_i) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, LOW: begin
                    if (pwm_q) begin
                        // Zero dead time hands over directly on the same edge.
                        if (dt_rise_i == '0) begin
                            state_next = HIGH;
                        end else begin
                            state_next = DT_H;
                            cnt_next   = dt_rise_i - DT_WIDTH'(1);
                        end
                    end else begin
                        state_next = LOW;
                    end
                end
                DT_H: begin
                    if (!pwm_q) begin
                        state_next = LOW;
                    end else if (cnt == '0) begin
                        state_next = HIGH;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (!pwm_q) begin
                        if (dt_fall_i == '0) begin
                            state_next = LOW;
                        end else begin
                            state_next = DT_L;
                            cnt_next   = dt_fall_i - DT_WIDTH'(1);
                        end
                    end
                end
                DT_L: begin
                    if (pwm_q) begin
                        state_next = HIGH;
                    end else if (cnt == '0) begin
                        state_next = LOW;
                    end else begin
                        cnt_next = cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        // An abandoned interval leaves nothing behind for the next one.
        if (state_next != DT_H && state_next != DT_L) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pwm_q   <= 1'b0;
            h_act   <= 1'b0;
            l_act   <= 1'b0;
            fault_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pwm_q   <= pwm_i;
            h_act   <= (state_next == HIGH);
            l_act   <= (state_next == LOW);
            fault_q <= (state_next == FAULT);
            busy_q  <= (state_next == DT_H) || (state_next == DT_L);
        end
    end

    assign pwm_h_o = h_act ^ pol_h_i;
    assign pwm_l_o = l_act ^ pol_l_i;
    assign fault_o = fault_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_timer_deadtime.sv
// Scoreboard bench for timer_deadtime: stimulus pushes per-edge expected outputs,
// a negedge monitor pops and compares them and also checks high/low never overlap.
module tb_timer_deadtime;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          pwm;
    logic [DW-1:0] dt_rise;
    logic [DW-1:0] dt_fall;
    logic          pol_h;
    logic          pol_l;
    logic          fault;
    logic          fault_clr;
    logic          pwm_h_o;
    logic          pwm_l_o;
    logic          fault_o;
    logic          busy_o;

    int edge_n   = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         at;
        logic [3:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    timer_deadtime #(.DT_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .pwm_i       (pwm),
        .dt_rise_i   (dt_rise),
        .dt_fall_i   (dt_fall),
        .pol_h_i     (pol_h),
        .pol_l_i     (pol_l),
        .fault_i     (fault),
        .fault_clr_i (fault_clr),
        .pwm_h_o     (pwm_h_o),
        .pwm_l_o     (pwm_l_o),
        .fault_o     (fault_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: edge %0d reached time limit", edge_n);
        $fatal(1, "timeout");
    end

    // Monitor: every negedge check overlap and pop all expectations due by this edge.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [3:0] got;
        if (edge_n > 0) begin
            n_checks++;
            if (((pwm_h_o ^ pol_h) === 1'b1) && ((pwm_l_o ^ pol_l) === 1'b1)) begin
                n_fail++;
                $display("FAIL overlap at edge %0d: both sides active (h=%b l=%b)",
                         edge_n, pwm_h_o, pwm_l_o);
            end
        end
        while (sb.size() > 0 && sb[0].at <= edge_n) begin
            e   = sb.pop_front();
            got = {pwm_h_o, pwm_l_o, fault_o, busy_o};
            n_checks++;
            if (e.at < edge_n) begin
                n_fail++;
                $display("FAIL %s: expectation for edge %0d missed (now edge %0d)",
                         e.tag, e.at, edge_n);
            end else if (got !== e.exp) begin
                n_fail++;
                $display("FAIL %s at edge %0d: got {h,l,f,b}=%b expected %b",
                         e.tag, edge_n, got, e.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected activity bits; pins are derived with the configured polarity.
    task automatic push(input int at, input bit h, input bit l, input bit f, input bit b,
                        input string tag);
        exp_t e;
        e.at  = at;
        e.exp = {h ^ pol_h, l ^ pol_l, f, b};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic hold(input int n, input bit h, input bit l, input bit f, input bit b,
                        input string tag);
        for (int i = 1; i <= n; i++) push(edge_n + i, h, l, f, b, tag);
        repeat (n) tick();
    endtask

    // pwm sampled at k: old side holds at k, off from k+1, new side on at k+1+dt.
    task automatic toggle(input bit nv, input int dt, input int total, input string tag);
        int k;
        pwm = nv;
        k   = edge_n + 1;
        push(k, ~nv, nv, 1'b0, 1'b0, tag);
        for (int j = 1; j <= dt; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b1, tag);
        for (int j = dt + 1; j < total; j++) push(k + j, nv, ~nv, 1'b0, 1'b0, tag);
        repeat (total) tick();
    endtask

    initial begin : stim
        int k;
        rst       = 1'b1;
        en        = 1'b0;
        pwm       = 1'b0;
        pol_h     = 1'b1;
        pol_l     = 1'b0;
        fault     = 1'b0;
        fault_clr = 1'b0;
        dt_rise   = 8'd3;
        dt_fall   = 8'd5;

        // Reset: pins show polarity only.
        hold(4, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        rst = 1'b0;
        hold(1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_after_rst");
        en = 1'b1;
        push(edge_n + 2, 1'b0, 1'b1, 1'b0, 1'b0, "enable_low");
        tick();
        tick();
        hold(3, 1'b0, 1'b1, 1'b0, 1'b0, "low_steady");

        // Dead time 3 / 5 with 20-cycle toggling.
        toggle(1'b1, 3, 20, "rise_dt3");
        toggle(1'b0, 5, 20, "fall_dt5");
        toggle(1'b1, 3, 20, "rise_dt3_b");
        toggle(1'b0, 5, 20, "fall_dt5_b");

        // Short pulse swallowed by dt_rise = 4.
        dt_rise = 8'd4;
        k   = edge_n + 1;
        pwm = 1'b1;
        push(k, 1'b0, 1'b1, 1'b0, 1'b0, "swallow");
        push(k + 1, 1'b0, 1'b0, 1'b0, 1'b1, "swallow");
        push(k + 2, 1'b0, 1'b0, 1'b0, 1'b1, "swallow");
        for (int j = 3; j <= 9; j++) push(k + j, 1'b0, 1'b1, 1'b0, 1'b0, "swallow");
        tick();
        tick();
        pwm = 1'b0;
        repeat (8) tick();

        // Zero dead time: same-edge handover, never busy.
        dt_rise = 8'd0;
        dt_fall = 8'd0;
        toggle(1'b1, 0, 10, "rise_dt0");
        toggle(1'b0, 0, 10, "fall_dt0");
        toggle(1'b1, 0, 10, "rise_dt0_b");
        toggle(1'b0, 0, 10, "fall_dt0_b");

        // Fault in HIGH with simultaneous clear, real clear 10 cycles later.
        dt_rise = 8'd3;
        dt_fall = 8'd5;
        toggle(1'b1, 3, 10, "to_high");
        fault     = 1'b1;
        fault_clr = 1'b1;
        k = edge_n + 1;
        push(k, 1'b0, 1'b0, 1'b1, 1'b0, "fault_entry");
        tick();
        fault     = 1'b0;
        fault_clr = 1'b0;
        for (int i = 1; i <= 9; i++) push(k + i, 1'b0, 1'b0, 1'b1, 1'b0, "fault_hold");
        repeat (9) tick();
        fault_clr = 1'b1;
        k = edge_n + 1;
        push(k, 1'b0, 1'b0, 1'b0, 1'b0, "fault_clr_idle");
        for (int j = 1; j <= 3; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b1, "resume_dth");
        push(k + 4, 1'b1, 1'b0, 1'b0, 1'b0, "resume_high");
        push(k + 5, 1'b1, 1'b0, 1'b0, 1'b0, "resume_high");
        tick();
        fault_clr = 1'b0;
        repeat (5) tick();

        // Long fall interval abandoned by en low.
        dt_fall = 8'd255;
        pwm = 1'b0;
        k   = edge_n + 1;
        push(k, 1'b1, 1'b0, 1'b0, 1'b0, "dt255_start");
        for (int j = 1; j <= 20; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b1, "dt255_busy");
        repeat (21) tick();
        en = 1'b0;
        hold(3, 1'b0, 1'b0, 1'b0, 1'b0, "en_off_idle");
        en = 1'b1;
        hold(5, 1'b0, 1'b1, 1'b0, 1'b0, "reenable_low");

        // Long fall interval abandoned by reset.
        toggle(1'b1, 3, 10, "rehigh");
        pwm = 1'b0;
        k   = edge_n + 1;
        push(k, 1'b1, 1'b0, 1'b0, 1'b0, "dt255_b_start");
        for (int j = 1; j <= 10; j++) push(k + j, 1'b0, 1'b0, 1'b0, 1'b1, "dt255_b_busy");
        repeat (11) tick();
        rst = 1'b1;
        hold(2, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid_idle");
        rst = 1'b0;
        hold(3, 1'b0, 1'b1, 1'b0, 1'b0, "after_rst_low");

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_deadtime.md
# timer_deadtime

Complementary PWM dead-time generator sitting directly downstream of the general timer's `pwm_o`. It converts the single-ended timer PWM into a high-side/low-side gate-drive pair. Programmable dead time is inserted on each transition, and the block has a sticky fault shutdown. Configuration inputs are static fields driven from the timer register space; outputs go to pads or gate drivers.

## Interface
- `DT_WIDTH`, default 8: width of the dead-time counters and configuration fields, in clock cycles.

Ports:
- `clk`: in, 1. Single clock, same domain as the timer.
- `rst`: in, 1. Synchronous, active-high reset.
- `en_i`: in, 1. Block enable. Low forces IDLE.
- `pwm_i`: in, 1. PWM from the timer (`pwm_o`). Synchronous to `clk`.
- `dt_rise_i`: in, `DT_WIDTH`. Dead cycles inserted before the high side turns on.
- `dt_fall_i`: in, `DT_WIDTH`. Dead cycles inserted before the low side turns on.
- `pol_h_i`: in, 1. 1 = high-side output is active-low.
- `pol_l_i`: in, 1. 1 = low-side output is active-low.
- `fault_i`: in, 1. Level fault request. Synchronous to `clk`.
- `fault_clr_i`: in, 1. Single-cycle pulse that clears a latched fault.
- `pwm_h_o`: out, 1. High-side drive.
- `pwm_l_o`: out, 1. Low-side drive.
- `fault_o`: out, 1. Fault latched.
- `busy_o`: out, 1. A dead-time interval is in progress.

## Operation
- `pwm_i` is registered once into `pwm_q`. Edge detection compares `pwm_q` against the current state.
- Internal registered activity bits are `h_act`, `l_act`, `fault_q` and `busy_q`.
- Output decode:
  - `pwm_h_o = h_act ^ pol_h_i`
  - `pwm_l_o = l_act ^ pol_l_i`
  - `fault_o = fault_q`, `busy_o = busy_q`
- FSM states: IDLE, LOW, DT_H, HIGH, DT_L, FAULT. Transition priority, highest first:
  - `fault_i` = 1 in any state → FAULT.
  - FAULT: stays until `fault_clr_i` = 1 and `fault_i` = 0, then → IDLE.
  - Outside FAULT, `en_i` = 0 → IDLE.
  - IDLE with `en_i` = 1: `pwm_q` = 0 → LOW; `pwm_q` = 1 → DT_H (or HIGH if `dt_rise_i` = 0).
  - LOW: `pwm_q` = 1 → DT_H, counter loaded with `dt_rise_i` − 1; if `dt_rise_i` = 0 → HIGH directly.
  - DT_H: `pwm_q` = 0 → LOW (pulse swallowed, no high-side output). Otherwise, counter = 0 → HIGH; else decrement.
  - HIGH: `pwm_q` = 0 → DT_L, counter loaded with `dt_fall_i` − 1; if `dt_fall_i` = 0 → LOW directly.
  - DT_L: `pwm_q` = 1 → HIGH (low side never turned on). Otherwise, counter = 0 → LOW; else decrement.
- Activity per state:
  - `h_act` = 1 only in HIGH.
  - `l_act` = 1 only in LOW.
  - IDLE, DT_H, DT_L and FAULT: both 0.
  - `busy_q` = 1 in DT_H and DT_L.
  - `fault_q` = 1 in FAULT.
- Invariant: `h_act` and `l_act` are never 1 in the same cycle.
- Dead-time fields are sampled only when the counter is loaded. Changes during an interval do not affect that interval.
- Polarity inputs are static configuration. Changing them while enabled glitches the outputs; this is software's responsibility.

## Timing
- Reset values: state IDLE, `h_act` = `l_act` = `fault_q` = `busy_q` = 0, counter 0, `pwm_q` 0. Therefore:
  - `pwm_h_o` = `pol_h_i`
  - `pwm_l_o` = `pol_l_i`
  - `fault_o` = 0, `busy_o` = 0
- Rising `pwm_i` sampled high at edge k, from LOW:
  - `l_act` falls at k+1.
  - `h_act` rises at k+1+`dt_rise_i`.
  - Both inactive for exactly `dt_rise_i` cycles.
- Falling `pwm_i` is symmetric using `dt_fall_i`.
- With dead time 0, one side falls and the other rises on the same edge, with no overlap.
- `fault_i` high at edge k: both sides inactive and `fault_o` = 1 from k+1. This holds regardless of `en_i` or `fault_clr_i` in the same cycle.
- `fault_clr_i` with `fault_i` low at edge k: IDLE at k+1, LOW earliest at k+2.
- `en_i` low at edge k: both inactive at k+1 and the counter is abandoned.
- `rst` mid-interval: IDLE on the next edge. Nothing is retained.
- Counter range: 0 to 2^`DT_WIDTH` − 1. Maximum dead time is 255 cycles at the default width.

## Test plan
- Reset with `pol_h_i` = 1, `pol_l_i` = 0, then enable with `pwm_i` = 0 → `pwm_h_o` = 1 and `pwm_l_o` = 0 during reset; `pwm_l_o` = 1 two edges after enable.
- `dt_rise_i` = 3, `dt_fall_i` = 5, `pwm_i` toggled every 20 cycles → exactly 3 and 5 both-inactive cycles at each edge, and never both active.
- `dt_rise_i` = 4 with a 2-cycle `pwm_i` pulse → high side never asserts; low side is off for 2 cycles then back on; `busy_o` high for 2 cycles.
- `dt_rise_i` = `dt_fall_i` = 0 → on each transition one side drops and the other rises on the same edge; `busy_o` stays 0.
- `fault_i` pulsed during HIGH, with `fault_clr_i` asserted in the same cycle and again 10 cycles later → both sides inactive next edge; `fault_o` stays 1 through the simultaneous clear; cleared only by the later clear; LOW or DT_H resumes afterwards.
- `dt_fall_i` = 255, then `en_i` dropped mid-interval and `rst` asserted mid-interval → IDLE next edge each time, `busy_o` = 0, no stale countdown after re-enable.
